// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM status encoding, the word type and the
// "no data" filler word returned on loads that are not completing.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam word_t BAD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every non-clock signal around mem_arbiter: the data port, the two
// instruction ports and the RAM side. slave = arbiter view, master = environment view.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic        dREN;
    logic        dWEN;
    word_t       daddr;
    word_t       dstore;
    logic        dwait;
    word_t       dload;

    logic  [1:0] iREN;
    word_t [1:0] iaddr;
    logic  [1:0] iwait;
    word_t [1:0] iload;

    logic        ramREN;
    logic        ramWEN;
    word_t       ramaddr;
    word_t       ramstore;
    word_t       ramload;
    ramstate_t   ramstate;

    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-RAM arbiter for one data port and two instruction ports (data first,
// round-robin between cores). Define MEM_ARB_FAIRNESS_EN for the data-streak starvation guard.
module mem_arbiter
    import cpu_types_pkg::word_t;
    import cpu_types_pkg::ramstate_t;
#(
    parameter word_t BAD         = cpu_types_pkg::BAD,
    parameter int    DSTREAK_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        dwait,
    output word_t       dload,
    input  logic  [1:0] iREN,
    input  word_t [1:0] iaddr,
    output logic  [1:0] iwait,
    output word_t [1:0] iload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  ramstate_t   ramstate
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DGRANT  = 2'd1,
        IGRANT0 = 2'd2,
        IGRANT1 = 2'd3
    } arb_state_t;

    arb_state_t state_q, state_d;
    logic       rr_q, rr_d;
    logic       data_req;
    logic       ram_done;
    logic       pick_core;
    logic       cur_core;
    logic       instr_first;

    if (DSTREAK_MAX < 1 || DSTREAK_MAX > 7) begin : g_bad_streak
        $error("mem_arbiter: DSTREAK_MAX must fit the 3-bit streak counter (1..7)");
    end

    assign data_req  = dREN | dWEN;
    assign ram_done  = (ramstate == cpu_types_pkg::ACCESS);
    assign pick_core = iREN[rr_q] ? rr_q : ~rr_q;
    assign cur_core  = (state_q == IGRANT1);

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [2:0] STREAK_LIM = 3'(DSTREAK_MAX);

    logic [2:0] streak_q, streak_d;
    logic       d_done;
    logic       i_done;

    assign d_done      = (state_q == DGRANT) && data_req && ram_done;
    assign i_done      = ((state_q == IGRANT0) || (state_q == IGRANT1)) && iREN[cur_core] && ram_done;
    assign instr_first = (streak_q >= STREAK_LIM) && (|iREN);

    // Only data wins taken at the expense of a waiting core count toward the streak.
    always_comb begin
        streak_d = streak_q;
        if (!(|iREN) || i_done) begin
            streak_d = '0;
        end else if (d_done && (streak_q != 3'd7)) begin
            streak_d = streak_q + 3'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign instr_first = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Outputs are purely combinational from state and live inputs, so a granted
    // requester sees its address/data changes on the RAM bus in the same cycle.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dwait    = 1'b1;
        dload    = BAD;
        iwait    = 2'b11;
        iload    = {BAD, BAD};

        unique case (state_q)
            IDLE: begin
                if (instr_first) begin
                    state_d = pick_core ? IGRANT1 : IGRANT0;
                end else if (data_req) begin
                    state_d = DGRANT;
                end else if (|iREN) begin
                    state_d = pick_core ? IGRANT1 : IGRANT0;
                end
            end

            DGRANT: begin
                if (!data_req) begin
                    state_d = IDLE;
                end else begin
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    ramaddr = daddr;
                    if (ram_done) begin
                        dwait   = 1'b0;
                        state_d = IDLE;
                        if (!dWEN) begin
                            dload = ramload;
                        end
                    end
                end
            end

            IGRANT0, IGRANT1: begin
                if (!iREN[cur_core]) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[cur_core];
                    if (ram_done) begin
                        iwait[cur_core] = 1'b0;
                        iload[cur_core] = ramload;
                        state_d         = IDLE;
                        rr_d            = ~cur_core;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle table with explicit RAM status,
// then scoreboarded grant sequences driven by a small RAM latency model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int GID_D  = 1;
    localparam int GID_I0 = 2;
    localparam int GID_I1 = 3;

    logic CLK = 1'b0;
    logic nRST;

    mem_arbiter_if bus();

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .dwait    (bus.dwait),
        .dload    (bus.dload),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .iwait    (bus.iwait),
        .iload    (bus.iload),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic      dren;
        logic      dwen;
        word_t     daddr;
        word_t     dstore;
        logic [1:0] iren;
        ramstate_t rs;
        word_t     rl;
        logic      e_ren;
        logic      e_wen;
        word_t     e_addr;
        word_t     e_store;
        logic      e_dwait;
        logic [1:0] e_iwait;
        word_t     e_dload;
        word_t     e_il0;
        word_t     e_il1;
    } vec_t;

    function automatic vec_t mk(input logic dren, input logic dwen, input word_t daddr,
                                input word_t dstore, input logic [1:0] iren,
                                input ramstate_t rs, input word_t rl,
                                input logic e_ren, input logic e_wen, input word_t e_addr,
                                input word_t e_store, input logic e_dwait,
                                input logic [1:0] e_iwait, input word_t e_dload,
                                input word_t e_il0, input word_t e_il1);
        vec_t v;
        v.dren = dren;   v.dwen = dwen;     v.daddr = daddr;     v.dstore = dstore;
        v.iren = iren;   v.rs = rs;         v.rl = rl;
        v.e_ren = e_ren; v.e_wen = e_wen;   v.e_addr = e_addr;   v.e_store = e_store;
        v.e_dwait = e_dwait; v.e_iwait = e_iwait;
        v.e_dload = e_dload; v.e_il0 = e_il0; v.e_il1 = e_il1;
        return v;
    endfunction

    vec_t tbl[21];

    // ---------------- scoreboard ----------------
    typedef struct {
        int    gid;
        word_t addr;
        logic  wen;
        word_t store;
        word_t load;
        int    cyc;
    } exp_t;

    exp_t sbq[$];

    logic       d_ren_f = 1'b0;
    logic       d_wen_f = 1'b0;
    logic [1:0] i_req_f = 2'b00;
    word_t      d_addr_v = '0;
    word_t      d_store_v = '0;
    int         lat = 2;
    int         ram_cnt = 0;

    function automatic word_t ram_data(input word_t a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic push(input int gid, input word_t addr, input logic wen,
                        input word_t store, input word_t load, input int cyc);
        exp_t e;
        e.gid = gid; e.addr = addr; e.wen = wen; e.store = store; e.load = load; e.cyc = cyc;
        sbq.push_back(e);
    endtask

    // Cycle 0 of a run is the IDLE arbitration cycle that sees the requests first.
    task automatic run(input int budget, input bit one_shot);
        int    cyc = 0;
        int    gid;
        word_t ld;
        exp_t  e;
        while (sbq.size() != 0 && cyc < budget) begin
            @(negedge CLK);
            bus.dREN     = d_ren_f;
            bus.dWEN     = d_wen_f;
            bus.daddr    = d_addr_v;
            bus.dstore   = d_store_v;
            bus.iREN     = i_req_f;
            bus.iaddr[0] = 32'h40;
            bus.iaddr[1] = 32'h80;
            #1;
            if (bus.ramREN || bus.ramWEN) begin
                if (ram_cnt >= lat) begin
                    bus.ramstate = ACCESS;
                    ram_cnt = 0;
                end else begin
                    bus.ramstate = BUSY;
                    ram_cnt++;
                end
            end else begin
                bus.ramstate = FREE;
                ram_cnt = 0;
            end
            bus.ramload = ram_data(bus.ramaddr);
            #1;
            e = sbq[0];
            check("ren_wen_excl", bus.ramREN & bus.ramWEN, 1'b0);
            check("one_wait_low", ($countones({~bus.dwait, ~bus.iwait}) <= 1), 1'b1);
            if (bus.ramREN || bus.ramWEN) begin
                check("grant_bus", {bus.ramWEN, bus.ramaddr}, {e.wen, e.addr});
                if (e.wen || e.gid != GID_D) check("grant_store", bus.ramstore, e.store);
            end
            if (bus.dwait)    check("dload_bad", bus.dload, BAD);
            if (bus.iwait[0]) check("iload0_bad", bus.iload[0], BAD);
            if (bus.iwait[1]) check("iload1_bad", bus.iload[1], BAD);
            gid = 0;
            ld  = BAD;
            if (!bus.dwait)    begin gid = GID_D;  ld = bus.dload;    end
            if (!bus.iwait[0]) begin gid = GID_I0; ld = bus.iload[0]; end
            if (!bus.iwait[1]) begin gid = GID_I1; ld = bus.iload[1]; end
            if (gid != 0) begin
                e = sbq.pop_front();
                $display("grant gid=%0d cycle=%0d load=%h (expected gid=%0d cycle=%0d)",
                         gid, cyc, ld, e.gid, e.cyc);
                check("grant_id", gid, e.gid);
                check("grant_cycle", cyc, e.cyc);
                check("grant_load", ld, e.load);
                if (one_shot) begin
                    if (gid == GID_D)  begin d_ren_f = 1'b0; d_wen_f = 1'b0; end
                    if (gid == GID_I0) i_req_f[0] = 1'b0;
                    if (gid == GID_I1) i_req_f[1] = 1'b0;
                end
            end
            cyc++;
        end
        if (sbq.size() != 0) begin
            check("grant_timeout", sbq.size(), 0);
            sbq.delete();
        end
        d_ren_f = 1'b0;
        d_wen_f = 1'b0;
        i_req_f = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-derived cycle table, starting in IDLE with rr=0.
        tbl[0]  = mk(0,0,'h000,0,2'b00,FREE,  'h0,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[1]  = mk(0,0,'h000,0,2'b01,FREE,  'h0,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[2]  = mk(0,0,'h000,0,2'b01,BUSY,  'hDEAD0001, 1,0,'h040,0,   1,2'b11,BAD,BAD,BAD);
        tbl[3]  = mk(0,0,'h000,0,2'b01,BUSY,  'hDEAD0001, 1,0,'h040,0,   1,2'b11,BAD,BAD,BAD);
        tbl[4]  = mk(0,0,'h000,0,2'b01,ACCESS,'h12345678, 1,0,'h040,0,   1,2'b10,BAD,'h12345678,BAD);
        tbl[5]  = mk(0,0,'h000,0,2'b00,FREE,  'h0,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[6]  = mk(1,0,'h200,0,2'b00,FREE,  'h0,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[7]  = mk(1,0,'h200,0,2'b00,BUSY,  'h5,        1,0,'h200,0,   1,2'b11,BAD,BAD,BAD);
        tbl[8]  = mk(0,0,'h200,0,2'b00,BUSY,  'h5,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[9]  = mk(0,0,'h200,0,2'b10,FREE,  'h0,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[10] = mk(0,0,'h200,0,2'b10,ACCESS,'hABCD0001, 1,0,'h080,0,   1,2'b01,BAD,BAD,'hABCD0001);
        tbl[11] = mk(1,1,'h300,'h55,2'b00,FREE,  'h0,     0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[12] = mk(1,1,'h300,'h55,2'b00,ACCESS,'h77,    0,1,'h300,'h55,0,2'b11,BAD,BAD,BAD);
        tbl[13] = mk(0,0,'h300,'h55,2'b00,FREE,  'h0,     0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[14] = mk(1,0,'h400,0,2'b00,FREE,  'h0,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[15] = mk(1,0,'h404,0,2'b00,BUSY,  'h0,        1,0,'h404,0,   1,2'b11,BAD,BAD,BAD);
        tbl[16] = mk(1,1,'h408,'h9,2'b00,ERROR,'h0,       0,1,'h408,'h9, 1,2'b11,BAD,BAD,BAD);
        tbl[17] = mk(0,0,'h408,'h9,2'b00,FREE,'h0,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[18] = mk(1,0,'h500,0,2'b00,FREE,  'h0,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);
        tbl[19] = mk(1,0,'h500,0,2'b00,ACCESS,'h600D,     1,0,'h500,0,   0,2'b11,'h600D,BAD,BAD);
        tbl[20] = mk(0,0,'h000,0,2'b00,FREE,  'h0,        0,0,'h000,0,   1,2'b11,BAD,BAD,BAD);

        // Reset held with active requests: outputs must sit at IDLE values.
        nRST         = 1'b0;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h10;
        bus.dstore   = 32'h20;
        bus.iREN     = 2'b11;
        bus.iaddr[0] = 32'h40;
        bus.iaddr[1] = 32'h80;
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h1;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_bus", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait, bus.iwait},
              {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b11});
        check("rst_loads", {bus.dload, bus.iload[0], bus.iload[1]}, {BAD, BAD, BAD});
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.iREN     = 2'b00;
        bus.ramstate = FREE;
        nRST         = 1'b1;

        foreach (tbl[i]) begin
            @(negedge CLK);
            bus.dREN     = tbl[i].dren;
            bus.dWEN     = tbl[i].dwen;
            bus.daddr    = tbl[i].daddr;
            bus.dstore   = tbl[i].dstore;
            bus.iREN     = tbl[i].iren;
            bus.ramstate = tbl[i].rs;
            bus.ramload  = tbl[i].rl;
            #1;
            check($sformatf("row%0d_bus", i),
                  {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait, bus.iwait},
                  {tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_addr, tbl[i].e_store, tbl[i].e_dwait, tbl[i].e_iwait});
            check($sformatf("row%0d_loads", i), {bus.dload, bus.iload[0], bus.iload[1]},
                  {tbl[i].e_dload, tbl[i].e_il0, tbl[i].e_il1});
        end

        // Simultaneous write + both cores: D, I0, I1 with one IDLE between grants.
        lat = 2; ram_cnt = 0;
        d_ren_f = 1'b0; d_wen_f = 1'b1; d_addr_v = 32'h100; d_store_v = 32'hCAFE; i_req_f = 2'b11;
        push(GID_D,  32'h100, 1'b1, 32'hCAFE, BAD,                3);
        push(GID_I0, 32'h040, 1'b0, 32'h0,    ram_data(32'h40),   7);
        push(GID_I1, 32'h080, 1'b0, 32'h0,    ram_data(32'h80),  11);
        run(40, 1'b1);

        // Both cores held: round-robin alternates.
        lat = 2; ram_cnt = 0;
        i_req_f = 2'b11;
        push(GID_I0, 32'h040, 1'b0, 32'h0, ram_data(32'h40),  3);
        push(GID_I1, 32'h080, 1'b0, 32'h0, ram_data(32'h80),  7);
        push(GID_I0, 32'h040, 1'b0, 32'h0, ram_data(32'h40), 11);
        push(GID_I1, 32'h080, 1'b0, 32'h0, ram_data(32'h80), 15);
        run(40, 1'b0);

        // Data read held against core 0.
        lat = 0; ram_cnt = 0;
        d_ren_f = 1'b1; d_wen_f = 1'b0; d_addr_v = 32'h200; d_store_v = 32'h0; i_req_f = 2'b01;
        for (int k = 0; k < 4; k++) push(GID_D, 32'h200, 1'b0, 32'h0, ram_data(32'h200), 2 * k + 1);
`ifdef MEM_ARB_FAIRNESS_EN
        push(GID_I0, 32'h040, 1'b0, 32'h0, ram_data(32'h40), 9);
`else
        push(GID_D, 32'h200, 1'b0, 32'h0, ram_data(32'h200), 9);
`endif
        run(40, 1'b0);

        // Single core-0 read leaves rr pointing at core 1.
        lat = 0; ram_cnt = 0;
        i_req_f = 2'b01;
        push(GID_I0, 32'h040, 1'b0, 32'h0, ram_data(32'h40), 1);
        run(20, 1'b1);

        // Reset asserted mid IGRANT1 BUSY.
        @(negedge CLK);
        bus.iREN     = 2'b10;
        bus.ramstate = FREE;
        @(negedge CLK);
        bus.ramstate = BUSY;
        #1;
        check("pre_rst_grant", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h80});
        #2;
        nRST = 1'b0;
        #1;
        check("rst_abort_bus", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iwait},
              {1'b0, 1'b0, 32'h0, 2'b11});
        check("rst_abort_loads", {bus.dload, bus.iload[0], bus.iload[1]}, {BAD, BAD, BAD});
        @(negedge CLK);
        bus.ramstate = ACCESS;
        #1;
        check("rst_no_done", {bus.ramREN, bus.dwait, bus.iwait}, {1'b0, 1'b1, 2'b11});
        bus.iREN     = 2'b00;
        bus.ramstate = FREE;
        nRST         = 1'b1;

        // rr cleared by reset: core 0 served first.
        lat = 1; ram_cnt = 0;
        i_req_f = 2'b11;
        push(GID_I0, 32'h040, 1'b0, 32'h0, ram_data(32'h40), 2);
        push(GID_I1, 32'h080, 1'b0, 32'h0, ram_data(32'h80), 5);
        run(30, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BAD, 32'hBAD1BAD1: value driven on every load output when not completing.
REQ-002 SHALL have parameter DSTREAK_MAX, 4: data-grant limit used only under REQ-024.
REQ-003 SHALL have ports, in this order:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- dREN, dWEN  in  1 each  data request from the coherence bus write-back/M2C path.
- daddr, dstore  in  32 each  data address / write data.
- dwait  out  1  data stall.
- dload  out  32  data read word.
- iREN  in  2  instruction read request, one bit per core.
- iaddr  in  2x32  instruction address per core.
- iwait  out  2  instruction stall per core.
- iload  out  2x32  instruction word per core.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address / write data.
- ramload  in  32  RAM read word.
- ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.

Function
REQ-004 SHALL implement a registered FSM with states IDLE, DGRANT, IGRANT0, IGRANT1.
REQ-005 From IDLE, next state SHALL be chosen in this priority order:
- dREN|dWEN -> DGRANT;
- else iREN[rr] -> IGRANTrr;
- else iREN[~rr] -> IGRANT(~rr);
- else stay in IDLE.
REQ-006 rr SHALL be a 1-bit round-robin pointer, toggled to the other core on each completed instruction grant.
REQ-007 In IDLE, all RAM strobes SHALL be 0, all waits 1, all loads BAD, and ramaddr/ramstore 0.
REQ-008 DGRANT, dWEN=1 (wins if both dREN and dWEN are set): ramWEN=1, ramREN=0, ramaddr=daddr, ramstore=dstore.
REQ-009 DGRANT, dREN only: ramREN=1, ramaddr=daddr.
REQ-010 IGRANTn: ramREN=1, ramaddr=iaddr[n], ramstore=0.
REQ-011 A grant completes in the cycle ramstate==ACCESS. That cycle the granted wait SHALL be 0 (combinational), its load SHALL equal ramload (reads only), and next state SHALL be IDLE.
REQ-012 BUSY, FREE and ERROR SHALL hold the grant with the granted wait=1.
REQ-013 Non-granted requesters SHALL see wait=1 and load=BAD in every state.
REQ-014 Minimum latency from request to wait=0 SHALL be 2 cycles: one IDLE arbitration cycle, then the ACCESS cycle. There SHALL be one mandatory IDLE cycle between back-to-back grants.
REQ-015 If the granted requester drops its request before ACCESS, strobes SHALL drop in the same cycle, next state SHALL be IDLE, and rr SHALL be unchanged.
REQ-016 A data request arriving while an instruction grant is in progress SHALL NOT pre-empt it.
REQ-017 Changes of daddr/dWEN during DGRANT SHALL pass straight through to the RAM outputs; no internal latching.
REQ-018 ramREN and ramWEN SHALL never be 1 in the same cycle.

Reset
REQ-019 nRST low SHALL asynchronously force state=IDLE, rr=0 and the streak counter to 0.
REQ-020 Asserting reset mid-grant SHALL abort the grant: strobes 0 immediately, no completion reported.
REQ-021 All outputs SHALL take the IDLE values of REQ-007 while reset is held.

Configuration
REQ-022 Macro MEM_ARB_FAIRNESS_EN SHALL compile the starvation guard in or out.
REQ-023 Without the macro, arbitration SHALL be the strict data-first order of REQ-005.
REQ-024 With the macro, a 3-bit streak counter SHALL count completed DGRANTs made while any iREN was high. When it reaches DSTREAK_MAX, the next IDLE arbitration SHALL grant the pending instruction request ahead of data. The counter SHALL clear on any completed instruction grant or when no iREN is pending.

Structure
REQ-025 ramstate_t, word_t and BAD SHALL live in cpu_types_pkg. The arbiter state enum SHALL be local to the module.
REQ-026 SHALL be a single module with no sub-modules.

Verification
REQ-027 Single read: iREN=01, iaddr[0]=0x40, ramstate=ACCESS after 2 BUSY cycles -> iwait[0] low exactly one cycle, iload[0]=ramload, iwait[1]=1 throughout.
REQ-028 Simultaneous requests: dWEN=1, daddr=0x100, dstore=0xCAFE, plus iREN=11 -> order is D, I0, I1, each separated by one IDLE cycle; ramWEN only during D.
REQ-029 Round-robin: iREN=11 held for 4 completions -> grants I0, I1, I0, I1.
REQ-030 Withdrawal and reset: dREN dropped during BUSY -> strobes 0 that cycle, IDLE next. nRST low during IGRANT1 BUSY -> ramREN=0 asynchronously, iwait=11.
REQ-031 MEM_ARB_FAIRNESS_EN defined, dREN held with iREN=01 -> the 5th grant is I0 after 4 data completions. With the macro undefined, I0 is never granted.
